// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - video/CPU/RAM bus bundle for the VRAM arbiter
interface vram_arbiter_if #(
   parameter int AW = 11,
   parameter int DW = 16
);
   logic            vid_req;
   logic [AW-1:0]   vid_addr;
   logic            vid_valid;
   logic [DW-1:0]   vid_data;
   logic            cpu_req;
   logic            cpu_we;
   logic [AW-1:0]   cpu_addr;
   logic [DW/8-1:0] cpu_be;
   logic [DW-1:0]   cpu_wdata;
   logic            cpu_ack;
   logic [DW-1:0]   cpu_rdata;
   logic [AW-1:0]   ram_addr;
   logic            ram_we;
   logic [DW/8-1:0] ram_be;
   logic [DW-1:0]   ram_wdata;
   logic [DW-1:0]   ram_rdata;
   logic            proto_err;

   modport master (
      output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata, ram_rdata,
      input  vid_valid, vid_data, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_be, ram_wdata,
             proto_err
   );

   modport slave (
      input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata, ram_rdata,
      output vid_valid, vid_data, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_be, ram_wdata,
             proto_err
   );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: fixed-latency video fetch, posted CPU writes, stalled CPU reads
module vram_arbiter #(
   parameter int AW = 11,
   parameter int DW = 16
) (
   input logic           clk,
   input logic           reset,
   vram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, VID_RD, WB_WR, CPU_RD} slot_t;

   slot_t           slot_q;
   slot_t           tag_q;
   slot_t           slot_d;
   logic            wb_full;
   logic [AW-1:0]   wb_addr;
   logic [DW/8-1:0] wb_be;
   logic [DW-1:0]   wb_data;
   logic            cpu_busy;
   logic            vid_req_q;
   logic            cpu_live;
   logic            wb_drain;
   logic            wr_accept;
   logic            rd_grant;

   always_comb begin
      cpu_live  = bus.cpu_req & ~cpu_busy;
      wb_drain  = wb_full & ~bus.vid_req;
      // the buffer slot frees on its drain cycle, so a new write may land in it then
      wr_accept = cpu_live & bus.cpu_we & (~wb_full | wb_drain);
      rd_grant  = cpu_live & ~bus.cpu_we & ~wb_full & ~bus.vid_req;
      slot_d    = IDLE;
      if (bus.vid_req)
         slot_d = VID_RD;
      else if (wb_full)
         slot_d = WB_WR;
      else if (rd_grant)
         slot_d = CPU_RD;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q        <= IDLE;
         tag_q         <= IDLE;
         wb_full       <= 1'b0;
         wb_addr       <= '0;
         wb_be         <= '0;
         wb_data       <= '0;
         cpu_busy      <= 1'b0;
         vid_req_q     <= 1'b0;
         bus.ram_addr  <= '0;
         bus.ram_we    <= 1'b0;
         bus.ram_be    <= '0;
         bus.ram_wdata <= '0;
         bus.vid_valid <= 1'b0;
         bus.vid_data  <= '0;
         bus.cpu_ack   <= 1'b0;
         bus.cpu_rdata <= '0;
         bus.proto_err <= 1'b0;
      end else begin
         slot_q <= slot_d;
         tag_q  <= slot_q;

         case (slot_d)
            VID_RD: begin
               bus.ram_addr <= bus.vid_addr;
               bus.ram_we   <= 1'b0;
               bus.ram_be   <= '0;
            end
            WB_WR: begin
               bus.ram_addr  <= wb_addr;
               bus.ram_we    <= 1'b1;
               bus.ram_be    <= wb_be;
               bus.ram_wdata <= wb_data;
            end
            CPU_RD: begin
               bus.ram_addr <= bus.cpu_addr;
               bus.ram_we   <= 1'b0;
               bus.ram_be   <= '0;
            end
            default: begin
               bus.ram_we <= 1'b0;
               bus.ram_be <= '0;
            end
         endcase

         wb_full <= wr_accept | (wb_full & ~wb_drain);
         if (wr_accept) begin
            wb_addr <= bus.cpu_addr;
            wb_be   <= bus.cpu_be;
            wb_data <= bus.cpu_wdata;
         end

         // requester stays locked out through its ACK cycle
         cpu_busy <= (cpu_busy & ~bus.cpu_ack) | wr_accept | rd_grant;

         bus.vid_valid <= (tag_q == VID_RD);
         if (tag_q == VID_RD)
            bus.vid_data <= bus.ram_rdata;

         bus.cpu_ack <= wr_accept | (tag_q == CPU_RD);
         if (tag_q == CPU_RD)
            bus.cpu_rdata <= bus.ram_rdata;

         vid_req_q     <= bus.vid_req;
         bus.proto_err <= bus.proto_err | (bus.vid_req & vid_req_q);
      end
   end
endmodule
